mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported unified memory between the fetch stage (read-only)
//  and the memory stage (read/write) of the 5-stage MIPS32 pipeline.
//  Grants one access at a time and holds the external memory request stable
//  until the memory acknowledges. Drives StallF/StallM so the pipeline freezes
//  while its access is pending. Adds a starvation guard for fetch and a timeout
//  watchdog.
// PARAMETERS
//  ADDR_W        32  address width
//  DATA_W        32  data width; byte enables are DATA_W/8 bits
//  STARVE_LIMIT   4  consecutive data grants with fetch waiting before fetch is forced (>=1)
//  TIMEOUT_CYC   64  max cycles in an access state without MemAck; 0 disables watchdog
// PORTS
//  CLK        in   1         clock, rising edge
//  CLR        in   1         reset, asynchronous, active-low
//  IReqF      in   1         fetch read request; held with IAddrF until IAckF
//  IAddrF     in   ADDR_W    fetch address
//  IRdataF    out  DATA_W    fetch read data, valid only while IAckF=1
//  IAckF      out  1         fetch access complete (1-cycle pulse)
//  DReqM      in   1         data request; held with DWeM/DAddrM/DWdataM/DBeM until DAckM
//  DWeM       in   1         1=write, 0=read
//  DAddrM     in   ADDR_W    data address
//  DWdataM    in   DATA_W    write data
//  DBeM       in   DATA_W/8  byte enables (write only)
//  DRdataM    out  DATA_W    data read data, valid only while DAckM=1
//  DAckM      out  1         data access complete (1-cycle pulse)
//  MemReq     out  1         request to memory, high for the whole access
//  MemWe/MemAddr/MemWdata/MemBe  out  1/ADDR_W/DATA_W/DATA_W/8  registered access fields
//  MemAck     in   1         memory done; MemRdata valid in the same cycle
//  MemRdata   in   DATA_W    memory read data
//  StallF     out  1         IReqF & ~IAckF
//  StallM     out  1         DReqM & ~DAckM
//  TimeoutErr out  1         sticky: a watchdog abort has occurred
// BEHAVIOUR
//  - FSM states: IDLE, I_ACC, D_ACC. MemReq = (state != IDLE).
//  - IDLE: when DReqM & IReqF & starve_cnt==STARVE_LIMIT -> I_ACC; else if DReqM -> D_ACC;
//    else if IReqF -> I_ACC; else stay in IDLE.
//    On the grant edge, the winner's fields are latched into Mem* (fetch: MemWe=0, MemBe=all 1s,
//    MemWdata=0).
//  - Grant latency: a request seen in IDLE in cycle n produces MemReq=1 in cycle n+1.
//  - X_ACC with MemAck=1: the matching ack is 1 in the same cycle (combinational),
//    Rdata=MemRdata, next state is IDLE. A read or write costs a minimum of 2 cycles.
//  - The requester changes or drops its request in the cycle after its ack. IDLE samples the
//    fresh request, so a held-over Req never double-grants.
//  - Mem* fields are stable for the whole access. A requester dropping Req mid-access does not
//    abort it; the access completes and the ack still pulses.
//  - starve_cnt (0..STARVE_LIMIT, saturating):
//    - D grant with IReqF=1: increment.
//    - D grant with IReqF=0: clear.
//    - I grant: clear.
//  - Watchdog: wait_cnt clears on grant and increments each X_ACC cycle. If TIMEOUT_CYC!=0 and
//    wait_cnt==TIMEOUT_CYC-1 with MemAck=0:
//    - ack pulses that cycle with Rdata forced to 0;
//    - TimeoutErr is set;
//    - next state is IDLE.
//    MemAck in the same cycle wins and is a normal completion.
//  - Reset (CLR=0, asynchronous, any state including mid-access):
//    - state=IDLE; MemReq=0 immediately, and memory must discard an in-flight access;
//    - Mem* regs=0, starve_cnt=0, wait_cnt=0, TimeoutErr=0;
//    - IAckF=DAckM=0; IRdataF=DRdataM=0;
//    - StallF=IReqF, StallM=DReqM.
//  - Ack and Rdata outputs are 0 whenever the matching state/MemAck condition is false.
// TESTING
//  1. Fetch only: IReqF=1 with IAddrF=0x100 and MemAck 2 cycles after MemReq ->
//     MemReq=1 for 2 cycles with MemAddr=0x100; IAckF pulses with IRdataF=MemRdata;
//     StallF=0 from the ack cycle.
//  2. Simultaneous IReqF and DReqM (write 0xDEADBEEF to 0x200, DBeM=4'b1111) ->
//     data granted first (MemWe=1); fetch granted on the next IDLE; StallF stays high until IAckF.
//  3. IReqF held high plus 5 back-to-back data requests, STARVE_LIMIT=4 ->
//     grant order D,D,D,D,I,D; starve_cnt returns to 0 after the I grant.
//  4. MemAck never asserted, TIMEOUT_CYC=64 -> ack pulses in the 64th access cycle with Rdata=0;
//     TimeoutErr=1 and stays set; the next request is served normally.
//  5. CLR pulsed low mid-access -> MemReq=0 asynchronously; no ack pulses;
//     after release the held request is re-granted with latency 1.
//  6. MemAck in the same cycle as the timeout -> normal completion with real MemRdata;
//     TimeoutErr remains 0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - pipeline/memory bus bundle for the unified memory port arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              IReqF;
    logic [ADDR_W-1:0] IAddrF;
    logic [DATA_W-1:0] IRdataF;
    logic              IAckF;

    logic              DReqM;
    logic              DWeM;
    logic [ADDR_W-1:0] DAddrM;
    logic [DATA_W-1:0] DWdataM;
    logic [BE_W-1:0]   DBeM;
    logic [DATA_W-1:0] DRdataM;
    logic              DAckM;

    logic              MemReq;
    logic              MemWe;
    logic [ADDR_W-1:0] MemAddr;
    logic [DATA_W-1:0] MemWdata;
    logic [BE_W-1:0]   MemBe;
    logic              MemAck;
    logic [DATA_W-1:0] MemRdata;

    logic              StallF;
    logic              StallM;
    logic              TimeoutErr;

    modport slave (
        input  IReqF, IAddrF, DReqM, DWeM, DAddrM, DWdataM, DBeM, MemAck, MemRdata,
        output IRdataF, IAckF, DRdataM, DAckM, MemReq, MemWe, MemAddr, MemWdata, MemBe,
        output StallF, StallM, TimeoutErr
    );

    modport master (
        output IReqF, IAddrF, DReqM, DWeM, DAddrM, DWdataM, DBeM, MemAck, MemRdata,
        input  IRdataF, IAckF, DRdataM, DAckM, MemReq, MemWe, MemAddr, MemWdata, MemBe,
        input  StallF, StallM, TimeoutErr
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for a single-ported unified memory
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT_CYC  = 64
) (
    input  logic               CLK,
    input  logic               CLR,
    mem_port_arbiter_if.slave  bus
);
    localparam int BE_W     = DATA_W / 8;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam int WAIT_W   = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    localparam logic [WAIT_W-1:0]   WAIT_LAST  = WAIT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    typedef enum logic [1:0] {IDLE, I_ACC, D_ACC} state_e;

    state_e              state_q, state_d;
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                timeout_err_q, timeout_err_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [BE_W-1:0]     mem_be_q, mem_be_d;

    logic in_acc;
    logic timeout_hit;
    logic acc_done;
    logic i_ack;
    logic d_ack;

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q       <= IDLE;
            starve_cnt_q  <= '0;
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_be_q      <= '0;
        end else begin
            state_q       <= state_d;
            starve_cnt_q  <= starve_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_be_q      <= mem_be_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        starve_cnt_d  = starve_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_be_d      = mem_be_q;

        in_acc      = (state_q != IDLE);
        // A real MemAck in the last allowed cycle beats the watchdog.
        timeout_hit = (TIMEOUT_CYC != 0) && in_acc && (wait_cnt_q == WAIT_LAST) && !bus.MemAck;
        acc_done    = in_acc && (bus.MemAck || timeout_hit);

        case (state_q)
            IDLE: begin
                if (bus.IReqF && (!bus.DReqM || starve_cnt_q == STARVE_MAX)) begin
                    state_d      = I_ACC;
                    wait_cnt_d   = '0;
                    starve_cnt_d = '0;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = bus.IAddrF;
                    mem_wdata_d  = '0;
                    mem_be_d     = '1;
                end else if (bus.DReqM) begin
                    state_d      = D_ACC;
                    wait_cnt_d   = '0;
                    mem_we_d     = bus.DWeM;
                    mem_addr_d   = bus.DAddrM;
                    mem_wdata_d  = bus.DWdataM;
                    mem_be_d     = bus.DBeM;
                    if (!bus.IReqF) begin
                        starve_cnt_d = '0;
                    end else if (starve_cnt_q != STARVE_MAX) begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
                end
            end
            I_ACC, D_ACC: begin
                if (acc_done) begin
                    state_d = IDLE;
                    if (timeout_hit) begin
                        timeout_err_d = 1'b1;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign i_ack = (state_q == I_ACC) && acc_done;
    assign d_ack = (state_q == D_ACC) && acc_done;

    assign bus.IAckF      = i_ack;
    assign bus.DAckM      = d_ack;
    assign bus.IRdataF    = ((state_q == I_ACC) && bus.MemAck) ? bus.MemRdata : '0;
    assign bus.DRdataM    = ((state_q == D_ACC) && bus.MemAck) ? bus.MemRdata : '0;
    assign bus.StallF     = bus.IReqF & ~i_ack;
    assign bus.StallM     = bus.DReqM & ~d_ack;
    assign bus.MemReq     = in_acc;
    assign bus.MemWe      = mem_we_q;
    assign bus.MemAddr    = mem_addr_q;
    assign bus.MemWdata   = mem_wdata_q;
    assign bus.MemBe      = mem_be_q;
    assign bus.TimeoutErr = timeout_err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 32;
    localparam int STARVE_LIMIT = 4;
    localparam int TIMEOUT_CYC  = 64;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } dop_t;

    logic CLK = 1'b0;
    logic CLR = 1'b0;
    always #5 CLK = ~CLK;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .CLK(CLK),
        .CLR(CLR),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] fq[$];
    dop_t        dq[$];
    bit          i_acked = 0;
    bit          d_acked = 0;

    int mem_lat = 2;
    int acc_cyc = 0;
    bit ack_raw = 0;
    assign bus.MemAck   = ack_raw & bus.MemReq;
    assign bus.MemRdata = bus.MemAck ? (bus.MemAddr ^ 32'hC0DE_0000) : (32'hBAD0_0000 ^ 32'(acc_cyc));

    // reference model: one outstanding access, integer bookkeeping
    bit          m_busy = 0, m_is_d = 0, m_err = 0, m_we = 0;
    int          m_n = 0, m_starve = 0;
    logic [31:0] m_addr = 0, m_wd = 0;
    logic [3:0]  m_be = 0;
    bit          s_ireq = 0, s_dreq = 0, s_dwe = 0, s_ack = 0, s_to = 0;
    logic [31:0] s_iaddr = 0, s_daddr = 0, s_dwd = 0;
    logic [3:0]  s_dbe = 0;

    string       dut_order = "";
    int          req_run = 0, last_len = 0;
    logic [31:0] last_addr = 0, last_rdata = 0, last_d_wdata = 0;
    logic        last_d_we = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_str(input string name, input string act, input string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got \"%s\" expected \"%s\" at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_timeout();
        return m_busy && (TIMEOUT_CYC != 0) && (m_n + 1 == TIMEOUT_CYC) && !bus.MemAck;
    endfunction

    // requesters and memory responder, driven just after each rising edge
    initial begin
        bus.IReqF = 0; bus.IAddrF = 0;
        bus.DReqM = 0; bus.DWeM = 0; bus.DAddrM = 0; bus.DWdataM = 0; bus.DBeM = 0;
        forever begin
            @(posedge CLK);
            #1;
            if (i_acked) begin
                if (fq.size() > 0) void'(fq.pop_front());
                i_acked = 0;
            end
            if (d_acked) begin
                if (dq.size() > 0) void'(dq.pop_front());
                d_acked = 0;
            end
            if (fq.size() > 0) begin
                bus.IReqF = 1; bus.IAddrF = fq[0];
            end else begin
                bus.IReqF = 0; bus.IAddrF = 0;
            end
            if (dq.size() > 0) begin
                bus.DReqM = 1; bus.DWeM = dq[0].we; bus.DAddrM = dq[0].addr;
                bus.DWdataM = dq[0].wdata; bus.DBeM = dq[0].be;
            end else begin
                bus.DReqM = 0; bus.DWeM = 0; bus.DAddrM = 0; bus.DWdataM = 0; bus.DBeM = 0;
            end
            acc_cyc = bus.MemReq ? acc_cyc + 1 : 0;
            ack_raw = (mem_lat != 0) && (acc_cyc == mem_lat);
        end
    end

    // model state advance
    initial begin
        forever begin
            @(posedge CLK or negedge CLR);
            if (!CLR) begin
                m_busy = 0; m_is_d = 0; m_err = 0; m_n = 0; m_starve = 0;
                m_we = 0; m_addr = 0; m_wd = 0; m_be = 0;
            end else if (!m_busy) begin
                if (s_ireq || s_dreq) begin
                    m_busy = 1;
                    m_n    = 0;
                    if (s_ireq && (!s_dreq || m_starve == STARVE_LIMIT)) begin
                        m_is_d = 0; m_we = 0; m_addr = s_iaddr; m_wd = 0; m_be = 4'hF;
                        m_starve = 0;
                    end else begin
                        m_is_d = 1; m_we = s_dwe; m_addr = s_daddr; m_wd = s_dwd; m_be = s_dbe;
                        m_starve = s_ireq ? ((m_starve < STARVE_LIMIT) ? m_starve + 1 : STARVE_LIMIT) : 0;
                    end
                end
            end else if (s_ack || s_to) begin
                m_busy = 0;
                if (s_to) m_err = 1;
            end else begin
                m_n++;
            end
        end
    end

    // compare process: every falling edge
    initial begin
        bit          to, fin, e_iack, e_dack;
        logic [31:0] e_ird, e_drd;
        forever begin
            @(negedge CLK);
            to     = model_timeout();
            fin    = m_busy && (bus.MemAck || to);
            e_iack = fin && !m_is_d;
            e_dack = fin && m_is_d;
            e_ird  = (e_iack && bus.MemAck) ? bus.MemRdata : 32'h0;
            e_drd  = (e_dack && bus.MemAck) ? bus.MemRdata : 32'h0;
            chk("MemReq",     32'(bus.MemReq),     32'(m_busy));
            chk("IAckF",      32'(bus.IAckF),      32'(e_iack));
            chk("DAckM",      32'(bus.DAckM),      32'(e_dack));
            chk("IRdataF",    bus.IRdataF,         e_ird);
            chk("DRdataM",    bus.DRdataM,         e_drd);
            chk("StallF",     32'(bus.StallF),     32'(bus.IReqF && !e_iack));
            chk("StallM",     32'(bus.StallM),     32'(bus.DReqM && !e_dack));
            chk("TimeoutErr", 32'(bus.TimeoutErr), 32'(m_err));
            chk("MemWe",      32'(bus.MemWe),      32'(m_we));
            chk("MemAddr",    bus.MemAddr,         m_addr);
            chk("MemWdata",   bus.MemWdata,        m_wd);
            chk("MemBe",      32'(bus.MemBe),      32'(m_be));

            req_run = bus.MemReq ? req_run + 1 : 0;
            if (bus.IAckF) begin
                i_acked = 1; dut_order = {dut_order, "I"};
                last_len = req_run; last_addr = bus.MemAddr; last_rdata = bus.IRdataF;
            end
            if (bus.DAckM) begin
                d_acked = 1; dut_order = {dut_order, "D"};
                last_len = req_run; last_addr = bus.MemAddr; last_rdata = bus.DRdataM;
                last_d_we = bus.MemWe; last_d_wdata = bus.MemWdata;
            end

            s_ireq = bus.IReqF; s_iaddr = bus.IAddrF;
            s_dreq = bus.DReqM; s_dwe = bus.DWeM; s_daddr = bus.DAddrM;
            s_dwd = bus.DWdataM; s_dbe = bus.DBeM;
            s_ack = bus.MemAck; s_to = to;
        end
    end

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        forever begin
            @(posedge CLK);
            #2;
            if (fq.size() == 0 && dq.size() == 0 && !bus.MemReq) break;
            n++;
            if (n >= budget) begin
                checks++; errors++;
                $display("FAIL %s: queues not drained after %0d cycles", name, budget);
                fq.delete(); dq.delete();
                break;
            end
        end
    endtask

    task automatic wait_memreq(input string name, input int budget);
        int n = 0;
        while (!bus.MemReq) begin
            @(posedge CLK);
            #2;
            n++;
            if (n >= budget) begin
                checks++; errors++;
                $display("FAIL %s: MemReq never rose within %0d cycles", name, budget);
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        repeat (3) @(posedge CLK);
        #2;
        chk("reset_MemReq", 32'(bus.MemReq), 32'h0);
        chk("reset_MemAddr", bus.MemAddr, 32'h0);
        @(posedge CLK);
        #3 CLR = 1;

        // fetch only, two-cycle memory
        dut_order = "";
        fq.push_back(32'h100);
        wait_done("t1", 50);
        chk_str("t1_order", dut_order, "I");
        chk("t1_len", 32'(last_len), 32'd2);
        chk("t1_addr", last_addr, 32'h100);
        chk("t1_rdata", last_rdata, 32'hC0DE_0100);

        // simultaneous write and fetch: data first
        dut_order = "";
        dq.push_back('{1'b1, 32'h200, 32'hDEAD_BEEF, 4'hF});
        fq.push_back(32'h300);
        wait_done("t2", 50);
        chk_str("t2_order", dut_order, "DI");
        chk("t2_we", 32'(last_d_we), 32'h1);
        chk("t2_wdata", last_d_wdata, 32'hDEAD_BEEF);

        // starvation guard
        dut_order = "";
        fq.push_back(32'h400);
        for (int k = 0; k < 5; k++)
            dq.push_back('{1'b0, 32'h500 + 32'(4 * k), 32'h1111_0000 + 32'(k), 4'h3});
        wait_done("t3", 100);
        chk_str("t3_order", dut_order, "DDDDID");
        chk("t3_model_starve", 32'(m_starve), 32'h0);

        // MemAck coincident with the watchdog cycle
        dut_order = "";
        mem_lat = 64;
        fq.push_back(32'h600);
        wait_done("t6", 120);
        chk("t6_len", 32'(last_len), 32'd64);
        chk("t6_rdata", last_rdata, 32'hC0DE_0600);
        chk("t6_err", 32'(bus.TimeoutErr), 32'h0);

        // watchdog abort, then normal service
        dut_order = "";
        mem_lat = 0;
        dq.push_back('{1'b0, 32'h700, 32'h0, 4'hF});
        wait_done("t4", 120);
        chk("t4_len", 32'(last_len), 32'd64);
        chk("t4_rdata", last_rdata, 32'h0);
        chk("t4_err", 32'(bus.TimeoutErr), 32'h1);
        mem_lat = 2;
        fq.push_back(32'h800);
        wait_done("t4b", 50);
        chk("t4b_rdata", last_rdata, 32'hC0DE_0800);
        chk("t4b_err_sticky", 32'(bus.TimeoutErr), 32'h1);

        // requester drops mid-access; access still completes
        dut_order = "";
        mem_lat = 4;
        fq.push_back(32'h900);
        wait_memreq("tk", 10);
        fq.delete();
        wait_done("tk", 50);
        chk_str("tk_order", dut_order, "I");
        chk("tk_len", 32'(last_len), 32'd4);
        chk("tk_rdata", last_rdata, 32'hC0DE_0900);

        // asynchronous clear mid-access
        dut_order = "";
        mem_lat = 0;
        fq.push_back(32'hA00);
        wait_memreq("t5", 10);
        repeat (3) @(posedge CLK);
        #3 CLR = 0;
        #1;
        chk("t5_async_memreq", 32'(bus.MemReq), 32'h0);
        chk("t5_async_err", 32'(bus.TimeoutErr), 32'h0);
        chk("t5_async_stallf", 32'(bus.StallF), 32'h1);
        repeat (2) @(posedge CLK);
        #3 CLR = 1;
        mem_lat = 2;
        @(posedge CLK);
        #1;
        chk("t5_regrant", 32'(bus.MemReq), 32'h1);
        wait_done("t5", 50);
        chk_str("t5_order", dut_order, "I");
        chk("t5_rdata", last_rdata, 32'hC0DE_0A00);
        chk("t5_err", 32'(bus.TimeoutErr), 32'h0);

        repeat (2) @(posedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
